// File: rtl/core_sequencer_if.sv
// Sequencer-to-datapath bus: instruction ROM port plus register-file/ALU control.
// The sequencer drives through master; the ROM/RF/ALU side connects through slave.
interface core_sequencer_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 24,
  parameter int DATA_W  = 16,
  parameter int RA_W    = 4
);
  logic [ADDR_W-1:0]  rom_addr;
  logic [INSTR_W-1:0] rom_data;
  logic [RA_W-1:0]    rf_ra;
  logic [RA_W-1:0]    rf_rb;
  logic [DATA_W-1:0]  rf_rdata_a;
  logic [1:0]         alu_op;
  logic [DATA_W-1:0]  imm;
  logic [1:0]         wsel;
  logic               we;
  logic [RA_W-1:0]    wa;

  modport master (
    output rom_addr, rf_ra, rf_rb, alu_op, imm, wsel, we, wa,
    input  rom_data, rf_rdata_a
  );

  modport slave (
    input  rom_addr, rf_ra, rf_rb, alu_op, imm, wsel, we, wa,
    output rom_data, rf_rdata_a
  );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC control unit: owns the PC, decodes 24-bit
// instructions and steers the register file / ALU, including the MINALL sweep.
module core_sequencer #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 24,
  parameter int NREGS   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  core_sequencer_if.master  bus,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              instr_done,
  output logic              illegal
);
  localparam int RA_W = $clog2(NREGS);
  localparam logic [RA_W-1:0] LAST_REG = RA_W'(NREGS - 1);

  localparam logic [1:0] FETCH  = 2'd0;
  localparam logic [1:0] DECODE = 2'd1;
  localparam logic [1:0] EXEC   = 2'd2;
  localparam logic [1:0] HALT   = 2'd3;

  localparam logic [3:0] OP_LOAD   = 4'd0;
  localparam logic [3:0] OP_MOV    = 4'd1;
  localparam logic [3:0] OP_ADD    = 4'd2;
  localparam logic [3:0] OP_XOR    = 4'd3;
  localparam logic [3:0] OP_MIN    = 4'd4;
  localparam logic [3:0] OP_LDPC   = 4'd5;
  localparam logic [3:0] OP_BR     = 4'd6;
  localparam logic [3:0] OP_MINALL = 4'd7;

  localparam logic [1:0] ALU_PASS_B = 2'd0;
  localparam logic [1:0] ALU_ADD    = 2'd1;
  localparam logic [1:0] ALU_XOR    = 2'd2;
  localparam logic [1:0] ALU_MIN    = 2'd3;

  localparam logic [1:0] WSEL_ALU = 2'd0;
  localparam logic [1:0] WSEL_IMM = 2'd1;
  localparam logic [1:0] WSEL_PC1 = 2'd2;

  logic [1:0]         state;
  logic [INSTR_W-1:0] ir;
  logic [RA_W-1:0]    idx;
  logic [3:0]         op;
  logic [RA_W-1:0]    rd;
  logic [RA_W-1:0]    rs;
  logic               last_step;

  function automatic logic [1:0] alu_sel(input logic [3:0] opcode);
    case (opcode)
      OP_ADD:            alu_sel = ALU_ADD;
      OP_XOR:            alu_sel = ALU_XOR;
      OP_MIN, OP_MINALL: alu_sel = ALU_MIN;
      default:           alu_sel = ALU_PASS_B;
    endcase
  endfunction

  assign op = ir[23:20];
  assign rd = RA_W'(ir[19:16]);
  assign rs = RA_W'(ir[15:12]);

  // MINALL holds EXEC until the counter reaches the last register
  assign last_step = (op != OP_MINALL) || (idx == LAST_REG);

  assign bus.rom_addr = pc;
  assign bus.imm      = ir[15:0];
  assign busy         = (state == DECODE) || (state == EXEC);
  assign instr_done   = (state == EXEC) && last_step && !rst;

  always_comb begin
    bus.rf_ra  = rd;
    bus.rf_rb  = rs;
    bus.wa     = rd;
    bus.alu_op = alu_sel(op);
    bus.wsel   = WSEL_ALU;
    bus.we     = 1'b0;
    if (op == OP_MINALL) begin
      bus.rf_ra = '0;
      bus.rf_rb = idx;
      bus.wa    = '0;
    end
    if (op == OP_LOAD) bus.wsel = WSEL_IMM;
    if (op == OP_LDPC) bus.wsel = WSEL_PC1;
    // Write is gated by rst so a reset landing mid-MINALL never commits
    if ((state == EXEC) && (op != OP_BR) && !rst) bus.we = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      pc      <= '0;
      ir      <= '0;
      idx     <= RA_W'(1);
      illegal <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (run) state <= DECODE;
        end
        DECODE: begin
          ir  <= bus.rom_data;
          idx <= RA_W'(1);
          if (bus.rom_data[23]) begin
            illegal <= 1'b1;
            state   <= HALT;
          end else begin
            state <= EXEC;
          end
        end
        EXEC: begin
          if (!last_step) begin
            idx <= idx + RA_W'(1);
          end else begin
            pc    <= (op == OP_BR) ? ADDR_W'(bus.rf_rdata_a) : pc + ADDR_W'(1);
            idx   <= RA_W'(1);
            state <= FETCH;
          end
        end
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end
endmodule
